// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard unit: forwarding, load-use, PC-write and multicycle stalls/flushes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 3,
  parameter int EXEC_LAT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*REG_AW-1:0]  RA_D,
  input  logic [NUM_SRC*REG_AW-1:0]  RA_E,
  input  logic [NUM_SRC-1:0]         RAValidD,
  input  logic [REG_AW-1:0]          WA3E,
  input  logic [REG_AW-1:0]          WA3M,
  input  logic [REG_AW-1:0]          WA3W,
  input  logic                       RegWriteE,
  input  logic                       RegWriteM,
  input  logic                       RegWriteW,
  input  logic                       MemtoRegE,
  input  logic                       MulStartE,
  input  logic                       PCSrcD,
  input  logic                       PCSrcE,
  input  logic                       PCSrcM,
  input  logic                       PCSrcW,
  input  logic                       BranchTakenE,
  output logic [NUM_SRC*2-1:0]       ForwardE,
  output logic                       StallF,
  output logic                       StallD,
  output logic                       StallE,
  output logic                       FlushD,
  output logic                       FlushE,
  output logic                       FlushM,
  output logic                       MulBusy
);

  localparam logic [REG_AW-1:0] C_PC_REG = {REG_AW{1'b1}};
  localparam int                C_CNT_W  = $clog2(EXEC_LAT) + 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LOAD =
    (EXEC_LAT >= 2) ? C_CNT_W'(EXEC_LAT - 2) : '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 mul_stall;
  logic                 ld_stall;
  logic                 pc_wr_pend;
  logic [NUM_SRC*2-1:0] fwd_sel;

  // R15 reads come from the PC path, so they are never forwarded.
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      logic [REG_AW-1:0] ra;
      assign ra = RA_E[i*REG_AW +: REG_AW];
      always_comb begin
        fwd_sel[i*2 +: 2] = 2'b00;
        if (ra != C_PC_REG) begin
          if (RegWriteM && (ra == WA3M))
            fwd_sel[i*2 +: 2] = 2'b10;
          else if (RegWriteW && (ra == WA3W))
            fwd_sel[i*2 +: 2] = 2'b01;
        end
      end
    end
  endgenerate

  always_comb begin
    ld_stall = 1'b0;
    if (MemtoRegE && RegWriteE && (WA3E != C_PC_REG)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (RAValidD[i] && (RA_D[i*REG_AW +: REG_AW] == WA3E))
          ld_stall = 1'b1;
      end
    end
  end

  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MulStartE && (EXEC_LAT >= 2)) begin
          mul_stall = 1'b1;
          cnt_d     = C_CNT_LOAD;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mul_stall = 1'b1;
          cnt_d     = cnt_q - C_CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset holds every stage flushed and nothing stalled.
  always_comb begin
    if (reset) begin
      ForwardE = '0;
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      FlushM   = 1'b1;
      MulBusy  = 1'b0;
    end else begin
      ForwardE = fwd_sel;
      StallF   = ld_stall | pc_wr_pend | mul_stall;
      StallD   = ld_stall | mul_stall;
      StallE   = mul_stall;
      FlushD   = pc_wr_pend | PCSrcW | BranchTakenE;
      FlushE   = (ld_stall | BranchTakenE) & ~mul_stall;
      FlushM   = mul_stall;
      MulBusy  = (state_q == BUSY);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl at EXEC_LAT = 4, 2 and 1.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

  localparam int AW = 4;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset;
  logic [NS*AW-1:0] RA_D, RA_E;
  logic [NS-1:0]    RAValidD;
  logic [AW-1:0]    WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulStartE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;

  logic [NS*2-1:0] fwd_o [3];
  logic sf_o [3], sd_o [3], se_o [3], fd_o [3], fe_o [3], fm_o [3], mb_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_dut
      hazard_ctrl #(
        .REG_AW  (AW),
        .NUM_SRC (NS),
        .EXEC_LAT((k == 0) ? 4 : ((k == 1) ? 2 : 1))
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .RA_D        (RA_D),
        .RA_E        (RA_E),
        .RAValidD    (RAValidD),
        .WA3E        (WA3E),
        .WA3M        (WA3M),
        .WA3W        (WA3W),
        .RegWriteE   (RegWriteE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegE   (MemtoRegE),
        .MulStartE   (MulStartE),
        .PCSrcD      (PCSrcD),
        .PCSrcE      (PCSrcE),
        .PCSrcM      (PCSrcM),
        .PCSrcW      (PCSrcW),
        .BranchTakenE(BranchTakenE),
        .ForwardE    (fwd_o[k]),
        .StallF      (sf_o[k]),
        .StallD      (sd_o[k]),
        .StallE      (se_o[k]),
        .FlushD      (fd_o[k]),
        .FlushE      (fe_o[k]),
        .FlushM      (fm_o[k]),
        .MulBusy     (mb_o[k])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: multicycle op tracked as "position of the op in Execute".
  int lat_of [3] = '{4, 2, 1};
  bit act [3];
  int pos [3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        act[k] = 1'b0;
        pos[k] = 0;
      end else if (act[k]) begin
        if (pos[k] == lat_of[k] - 1) act[k] = 1'b0;
        else pos[k] = pos[k] + 1;
      end else if (MulStartE && lat_of[k] >= 2) begin
        act[k] = 1'b1;
        pos[k] = 1;
      end
    end
  end

  function automatic logic [NS*2-1:0] model_fwd();
    logic [NS*2-1:0] r;
    logic [AW-1:0]   a;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      a = RA_E[i*AW +: AW];
      if (a == 4'd15)                 r[i*2 +: 2] = 2'b00;
      else if (RegWriteM && a == WA3M) r[i*2 +: 2] = 2'b10;
      else if (RegWriteW && a == WA3W) r[i*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic bit model_ld();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (RAValidD[i] && RA_D[i*AW +: AW] == WA3E) hit = 1'b1;
    return MemtoRegE && RegWriteE && (WA3E != 4'd15) && hit;
  endfunction

  always @(negedge clk) begin
    bit ld, pcw, ms;
    ld  = model_ld();
    pcw = PCSrcD | PCSrcE | PCSrcM;
    for (int k = 0; k < 3; k++) begin
      ms = act[k] ? (pos[k] < lat_of[k] - 1) : (MulStartE && lat_of[k] >= 2);
      if (reset) begin
        chk($sformatf("m%0d ForwardE", k), 32'(fwd_o[k]), 32'd0);
        chk($sformatf("m%0d StallF", k), 32'(sf_o[k]), 32'd0);
        chk($sformatf("m%0d StallD", k), 32'(sd_o[k]), 32'd0);
        chk($sformatf("m%0d StallE", k), 32'(se_o[k]), 32'd0);
        chk($sformatf("m%0d FlushD", k), 32'(fd_o[k]), 32'd1);
        chk($sformatf("m%0d FlushE", k), 32'(fe_o[k]), 32'd1);
        chk($sformatf("m%0d FlushM", k), 32'(fm_o[k]), 32'd1);
        chk($sformatf("m%0d MulBusy", k), 32'(mb_o[k]), 32'd0);
      end else begin
        chk($sformatf("m%0d ForwardE", k), 32'(fwd_o[k]), 32'(model_fwd()));
        chk($sformatf("m%0d StallF", k), 32'(sf_o[k]), 32'(ld | pcw | ms));
        chk($sformatf("m%0d StallD", k), 32'(sd_o[k]), 32'(ld | ms));
        chk($sformatf("m%0d StallE", k), 32'(se_o[k]), 32'(ms));
        chk($sformatf("m%0d FlushD", k), 32'(fd_o[k]), 32'(pcw | PCSrcW | BranchTakenE));
        chk($sformatf("m%0d FlushE", k), 32'(fe_o[k]), 32'((ld | BranchTakenE) & ~ms));
        chk($sformatf("m%0d FlushM", k), 32'(fm_o[k]), 32'(ms));
        chk($sformatf("m%0d MulBusy", k), 32'(mb_o[k]), 32'(act[k]));
      end
    end
  end

  task automatic clear();
    RA_D = '0; RA_E = '0; RAValidD = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MulStartE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear();
    repeat (n) tick();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int p;
    p = $urandom_range(0, 4);
    return (p == 4) ? 4'd15 : AW'(p + 3);
  endfunction

  initial begin
    int cnt_a, cnt_b;
    clear();
    reset = 1'b1;
    RA_E[3:0] = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; PCSrcD = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset ForwardE", 32'(fwd_o[0]), 32'd0);
    chk("reset StallF", 32'(sf_o[0]), 32'd0);
    chk("reset FlushD", 32'(fd_o[0]), 32'd1);
    chk("reset FlushM", 32'(fm_o[0]), 32'd1);
    tick();
    reset = 1'b0;
    idle(1);

    // Forwarding priority and PC exclusion
    RA_E[3:0] = 4'd3; WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
    @(negedge clk); chk("fwd M", 32'(fwd_o[0][1:0]), 32'h2);
    tick(); RegWriteM = 0;
    @(negedge clk); chk("fwd W", 32'(fwd_o[0][1:0]), 32'h1);
    tick(); RA_E[3:0] = 4'd15; WA3W = 4'd15;
    @(negedge clk); chk("fwd PC", 32'(fwd_o[0][1:0]), 32'h0);

    // Load-use
    tick(); clear();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA_D[7:4] = 4'd5; RAValidD = 3'b010;
    @(negedge clk);
    chk("ld StallF", 32'(sf_o[0]), 32'd1);
    chk("ld StallD", 32'(sd_o[0]), 32'd1);
    chk("ld FlushE", 32'(fe_o[0]), 32'd1);
    tick(); RAValidD = 3'b000;
    @(negedge clk);
    chk("ld off StallF", 32'(sf_o[0]), 32'd0);
    chk("ld off StallD", 32'(sd_o[0]), 32'd0);
    chk("ld off FlushE", 32'(fe_o[0]), 32'd0);

    // Multicycle op, EXEC_LAT=4, start held for 4 cycles
    tick(); clear();
    for (int c = 0; c < 5; c++) begin
      MulStartE = (c < 4);
      @(negedge clk);
      chk($sformatf("mul4 StallE c%0d", c), 32'(se_o[0]), 32'(c < 3));
      chk($sformatf("mul4 FlushM c%0d", c), 32'(fm_o[0]), 32'(c < 3));
      chk($sformatf("mul4 MulBusy c%0d", c), 32'(mb_o[0]), 32'(c >= 1 && c <= 3));
      tick();
    end
    idle(4);

    // Single start pulse: stall cycles for EXEC_LAT=2 and 1
    cnt_a = 0; cnt_b = 0;
    MulStartE = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cnt_a += int'(sd_o[1]);
      cnt_b += int'(sd_o[2]);
      tick();
      MulStartE = 0;
    end
    chk("mul2 stall cycles", 32'(cnt_a), 32'd1);
    chk("mul1 stall cycles", 32'(cnt_b), 32'd0);
    idle(2);

    // PC write walking down the pipe
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 5; c++) begin
      PCSrcD = (c == 0); PCSrcE = (c == 1); PCSrcM = (c == 2); PCSrcW = (c == 3);
      @(negedge clk);
      cnt_a += int'(sf_o[0]);
      cnt_b += int'(fd_o[0]);
      tick();
    end
    chk("pc StallF cycles", 32'(cnt_a), 32'd3);
    chk("pc FlushD cycles", 32'(cnt_b), 32'd4);
    clear(); BranchTakenE = 1;
    @(negedge clk);
    chk("br FlushD", 32'(fd_o[0]), 32'd1);
    chk("br FlushE", 32'(fe_o[0]), 32'd1);
    idle(2);

    // Reset in BUSY with cnt=1 aborts the op
    MulStartE = 1; tick();
    MulStartE = 0; tick();
    reset = 1;
    @(negedge clk); chk("rst busy MulBusy", 32'(mb_o[0]), 32'd0);
    tick(); reset = 0;
    @(negedge clk);
    chk("post rst MulBusy", 32'(mb_o[0]), 32'd0);
    chk("post rst StallE", 32'(se_o[0]), 32'd0);
    chk("post rst StallF", 32'(sf_o[0]), 32'd0);
    tick();

    // Load-use collides with multicycle start
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA_D[3:0] = 4'd5; RAValidD = 3'b001;
    MulStartE = 1;
    @(negedge clk);
    chk("coll FlushE", 32'(fe_o[0]), 32'd0);
    chk("coll StallE", 32'(se_o[0]), 32'd1);
    chk("coll StallD", 32'(sd_o[0]), 32'd1);
    tick();
    idle(4);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NS; i++) begin
        RA_D[i*AW +: AW] = rnd_addr();
        RA_E[i*AW +: AW] = rnd_addr();
      end
      RAValidD  = NS'($urandom);
      WA3E = rnd_addr(); WA3M = rnd_addr(); WA3W = rnd_addr();
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      MulStartE = ($urandom_range(0, 5) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = MulStartE ? 1'b0 : ($urandom_range(0, 7) == 0);
      tick();
    end
    reset = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- REG_AW, 4, register-address width.
- NUM_SRC, 3, source operands per instruction (Rn, Rm, Rs).
- EXEC_LAT, 4, execute-stage occupancy in cycles of a multicycle op (multiply); legal values 1..16.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- RA_D, in, NUM_SRC*REG_AW, Decode source addresses; source i occupies slice [i*REG_AW +: REG_AW].
- RA_E, in, NUM_SRC*REG_AW, Execute source addresses, same packing.
- RAValidD, in, NUM_SRC, bit i set when source i is actually read in Decode.
- WA3E, WA3M, WA3W, in, REG_AW each, destination addresses in Execute, Memory and Writeback.
- RegWriteE, RegWriteM, RegWriteW, in, 1 each, destination write enables.
- MemtoRegE, in, 1, Execute instruction is a load.
- MulStartE, in, 1, Execute instruction is a multicycle op.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW, in, 1 each, instruction writes R15.
- BranchTakenE, in, 1, branch resolved taken in Execute.
- ForwardE, out, NUM_SRC*2, per-source forward select.
- StallF, StallD, StallE, out, 1 each, stage stalls.
- FlushD, FlushE, FlushM, out, 1 each, stage flushes.
- MulBusy, out, 1, multicycle sequencer active.

Function
REQ-003 PC_REG SHALL be 2**REG_AW-1, i.e. R15 at the default width.
REQ-004 ForwardE source i SHALL select as follows; source addresses equal to PC_REG are never forwarded (value 00):
- 10 when RA_E[i]==WA3M and RegWriteM;
- else 01 when RA_E[i]==WA3W and RegWriteW;
- else 00.
REQ-005 LdStall SHALL be 1 when MemtoRegE, RegWriteE, WA3E!=PC_REG, and, for some i, RAValidD[i] and RA_D[i]==WA3E.
REQ-006 PCWrPend SHALL equal PCSrcD|PCSrcE|PCSrcM.
REQ-007 The multicycle sequencer SHALL have states IDLE and BUSY, and a counter cnt of width clog2(EXEC_LAT)+1.
REQ-008 In IDLE with MulStartE=1 and EXEC_LAT>=2, MulStall SHALL be 1, cnt SHALL load EXEC_LAT-2, and the next state SHALL be BUSY.
REQ-009 In BUSY with cnt!=0, MulStall SHALL be 1, cnt SHALL decrement, and the state SHALL stay BUSY.
REQ-010 In BUSY with cnt==0 (release cycle), MulStall SHALL be 0, MulStartE SHALL be ignored, and the next state SHALL be IDLE.
REQ-011 The multicycle op SHALL therefore occupy Execute for exactly EXEC_LAT cycles, with EXEC_LAT-1 stall cycles.
REQ-012 With EXEC_LAT==1, MulStartE SHALL be ignored: the state stays IDLE and MulStall stays 0.
REQ-013 MulBusy SHALL be 1 exactly when the state is BUSY.
REQ-014 The stall outputs SHALL be:
- StallF = LdStall | PCWrPend | MulStall;
- StallD = LdStall | MulStall;
- StallE = MulStall.
REQ-015 The flush outputs SHALL be:
- FlushD = PCWrPend | PCSrcW | BranchTakenE;
- FlushE = (LdStall | BranchTakenE) & ~MulStall;
- FlushM = MulStall.
REQ-016 When LdStall and MulStall are both 1, MulStall SHALL take precedence: Decode is held and Execute is held, not flushed.
REQ-017 BranchTakenE SHALL be 0 whenever MulStartE is 1 (input contract); the block need not check it.
REQ-018 ForwardE SHALL be evaluated every cycle, including stall cycles.

Reset
REQ-019 On a rising clk edge with reset=1, the state SHALL become IDLE and cnt SHALL become 0.
REQ-020 While reset=1, the outputs SHALL be forced as follows:
- StallF, StallD, StallE = 0;
- FlushD, FlushE, FlushM = 1;
- ForwardE = 0;
- MulBusy = 0.
REQ-021 A reset asserted in BUSY SHALL abort the op; the first cycle after reset deasserts SHALL be IDLE with MulStall=0.

Verification
REQ-022 Source-operand forwarding: RA_E src0=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardE src0=10. Then clear RegWriteM -> 01. Then RA_E src0=15 -> 00.
REQ-023 Load-use stall: MemtoRegE=1, RegWriteE=1, WA3E=5, RA_D src1=5, RAValidD=010 -> StallF=StallD=FlushE=1 for one cycle. Same stimulus with RAValidD=000 -> all three 0.
REQ-024 Multicycle op: EXEC_LAT=4, MulStartE held high 4 cycles from IDLE -> StallF/D/E=FlushM=1 in cycles 0-2 and 0 in cycle 3; MulBusy=1 in cycles 1-3; state IDLE in cycle 4.
REQ-025 Multicycle op with EXEC_LAT=2 and EXEC_LAT=1 -> exactly 1 and 0 stall cycles respectively.
REQ-026 PC write: PCSrcD=1 then PCSrcE, PCSrcM, PCSrcW each 1 in consecutive cycles -> StallF=1 for 3 cycles; FlushD=1 for 4 cycles. Separately, BranchTakenE=1 -> FlushD=FlushE=1 in the same cycle.
REQ-027 Reset mid-op and collision: reset pulsed in BUSY with cnt=1 -> the next cycle is IDLE with all stalls 0. MulStall and LdStall both 1 -> FlushE=0 and StallE=1.
